// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the 5-stage RISC-V core.
//   stage_state_t : occupancy FSM of a pipeline stage; the encoding equals the entry count.
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) injected as a bubble.
//   *_W           : payload widths of the four stage registers.
//   IFID_BUBBLE   : IF/ID bubble payload, {instr, PC, PCPlus4} with NOP in the top word.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_BOTH  = 2'd2
    } stage_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned IFID_W  = 96;   // {instr, pc, pc_plus4}
    localparam int unsigned IDEX_W  = 160;  // {rs1_val, rs2_val, imm, pc, ctrl}
    localparam int unsigned EXMEM_W = 112;  // {alu_res, store_val, rd, ctrl}
    localparam int unsigned MEMWB_W = 104;  // {load_val, alu_res, rd, ctrl}

    localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, 64'h0};

    // Number of entries held in a given state.
    function automatic logic [1:0] state_occupancy(stage_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Occupancy controller of a pipeline stage.
//   clk_i, reset_i     : clock, synchronous active-high reset
//   flush_i            : kill all held entries on the next edge
//   in_valid_i         : upstream beat present
//   out_ready_i        : downstream accepts (low = stall)
//   in_ready_o         : stage accepts this cycle
//   out_valid_o        : main register holds a beat
//   occupancy_o        : entries held (state encoding)
//   load_main_o        : main register captures in_data this edge
//   load_skid_o        : skid register captures in_data this edge
//   skid_to_main_o     : main register captures the skid register this edge
// SKID=1 uses a 2-entry skid with in_ready from a flop; SKID=0 never enters ST_BOTH and
// in_ready is combinational.
module pipe_stage_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter bit SKID = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       flush_i,
    input  logic       in_valid_i,
    input  logic       out_ready_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic [1:0] occupancy_o,
    output logic       load_main_o,
    output logic       load_skid_o,
    output logic       skid_to_main_o
);

    stage_state_t state_q, state_d;
    // Registered "full" flag; reset value 0 makes in_ready=1 during and after reset.
    logic         full_q, full_d;
    logic         accept, send;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign occupancy_o = state_occupancy(state_q);
    assign in_ready_o  = SKID ? ~full_q : ((state_q == ST_EMPTY) | out_ready_i);
    assign accept      = in_valid_i & in_ready_o;
    assign send        = out_valid_o & out_ready_i;

    always_comb begin
        state_d        = state_q;
        load_main_o    = 1'b0;
        load_skid_o    = 1'b0;
        skid_to_main_o = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d     = ST_MAIN;
                    load_main_o = 1'b1;
                end
            end
            ST_MAIN: begin
                if (accept && send) begin
                    load_main_o = 1'b1;
                end else if (accept) begin
                    // Only reachable with SKID=1; SKID=0 ties off ST_BOTH.
                    if (SKID) begin
                        state_d     = ST_BOTH;
                        load_skid_o = 1'b1;
                    end else begin
                        load_main_o = 1'b1;
                    end
                end else if (send) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_BOTH: begin
                if (send) begin
                    state_d        = ST_MAIN;
                    skid_to_main_o = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A beat accepted in the flush cycle is discarded with the rest.
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
        full_d = (state_d == ST_BOTH);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_EMPTY;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   clk_i, reset_i : clock, synchronous active-high reset
//   flush_i        : synchronous kill of all held entries
//   in_valid_i/in_ready_o/in_data_i    : upstream valid/ready handshake and payload
//   out_valid_o/out_ready_i/out_data_o : downstream handshake; out_data_o = BUBBLE when invalid
//   occupancy_o    : entries held (0..1 for SKID=0, 0..2 for SKID=1)
// SKID=0: single register. SKID=1: main + skid register, registered in_ready.
module pipe_stage_buf
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned       WIDTH  = 96,
    parameter bit                SKID   = 1'b1,
    parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o
);

    logic             load_main, load_skid, skid_to_main;
    logic [WIDTH-1:0] main_q, main_d, skid_data;

    pipe_stage_ctrl #(
        .SKID (SKID)
    ) u_ctrl (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .out_ready_i    (out_ready_i),
        .in_ready_o     (in_ready_o),
        .out_valid_o    (out_valid_o),
        .occupancy_o    (occupancy_o),
        .load_main_o    (load_main),
        .load_skid_o    (load_skid),
        .skid_to_main_o (skid_to_main)
    );

    generate
        if (SKID) begin : g_skid
            logic [WIDTH-1:0] skid_q;
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    skid_q <= BUBBLE;
                end else if (load_skid) begin
                    skid_q <= in_data_i;
                end
            end
            assign skid_data = skid_q;
        end else begin : g_noskid
            logic unused_load_skid;
            assign unused_load_skid = load_skid;
            assign skid_data        = BUBBLE;
        end
    endgenerate

    always_comb begin
        main_d = main_q;
        if (load_main) begin
            main_d = in_data_i;
        end else if (skid_to_main) begin
            main_d = skid_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            main_q <= BUBBLE;
        end else begin
            main_q <= main_d;
        end
    end

    // The skid register is never visible; an empty or flushed stage shows the bubble.
    assign out_data_o = out_valid_o ? main_q : BUBBLE;

    a_bubble_when_idle : assert property (@(posedge clk_i)
        !out_valid_o |-> (out_data_o == BUBBLE));

    a_ready_when_empty : assert property (@(posedge clk_i) disable iff (reset_i)
        (occupancy_o == 2'd0) |-> in_ready_o);

    a_stall_stable : assert property (@(posedge clk_i) disable iff (reset_i)
        $past(out_valid_o & ~out_ready_i & ~flush_i & ~reset_i)
            |-> (out_data_o == $past(out_data_o)));

endmodule
